// File: rtl/envelope_shaper_adsr_if.sv
// Sample stream and status bundle for envelope_shaper_adsr.
// The producer/observer side uses master; the shaper uses slave.
interface envelope_shaper_adsr_if #(
    parameter int DATA_W = 16,
    parameter int GAIN_W = 10
);
    logic                     enable;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_sample;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_sample;
    logic        [GAIN_W-1:0] gain_out;
    logic        [2:0]        state_out;
    logic                     note_active;

    modport master (
        output enable, in_valid, in_sample,
        input  out_valid, out_sample, gain_out, state_out, note_active
    );

    modport slave (
        input  enable, in_valid, in_sample,
        output out_valid, out_sample, gain_out, state_out, note_active
    );
endinterface

// File: rtl/envelope_shaper_adsr.sv
// Five-state envelope shaper for the trumpet DSP chain: level-driven
// attack/sustain/hold/release gain with hysteresis, applied through a
// two-stage valid-qualified pipeline with round-half-up and saturation.
// Optional macro ENV_NOISE_GATE_EN: samples that leave the machine in IDLE
// (with shaping enabled) are output as zero.
//
// state   | meaning
// IDLE    | no note, gain parked at MIN_GAIN
// ATTACK  | gain ramping up by ATTACK_STEP toward MAX_GAIN
// SUSTAIN | note held, gain pinned at MAX_GAIN
// HOLD    | note dropped, gain frozen while the hold counter runs out
// RELEASE | gain ramping down by RELEASE_STEP toward MIN_GAIN
module envelope_shaper_adsr #(
    parameter int DATA_W       = 16,
    parameter int GAIN_W       = 10,
    parameter int GAIN_FRAC    = 8,
    parameter int MIN_GAIN     = 64,
    parameter int MAX_GAIN     = 256,
    parameter int ATTACK_STEP  = 8,
    parameter int RELEASE_STEP = 4,
    parameter int THRESHOLD    = 100,
    parameter int HYST         = 20,
    parameter int HOLD_SAMPLES = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    envelope_shaper_adsr_if.slave bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ATTACK  = 3'd1;
    localparam logic [2:0] S_SUSTAIN = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    localparam int HC_W = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
    localparam int PW   = DATA_W + GAIN_W + 1;

    // Gain arithmetic is one bit wider than the register so steps cannot wrap before the clamp.
    localparam logic [GAIN_W:0]   MIN_G   = (GAIN_W+1)'(MIN_GAIN);
    localparam logic [GAIN_W:0]   MAX_G   = (GAIN_W+1)'(MAX_GAIN);
    localparam logic [GAIN_W:0]   ATK_G   = (GAIN_W+1)'(ATTACK_STEP);
    localparam logic [GAIN_W:0]   REL_G   = (GAIN_W+1)'(RELEASE_STEP);
    localparam logic [GAIN_W:0]   IDLE_UP = (MIN_GAIN + ATTACK_STEP >= MAX_GAIN) ?
                                            MAX_G : (GAIN_W+1)'(MIN_GAIN + ATTACK_STEP);
    localparam logic [GAIN_W-1:0] MIN_GN  = GAIN_W'(MIN_GAIN);
    localparam logic [GAIN_W-1:0] MAX_GN  = GAIN_W'(MAX_GAIN);
    localparam logic [HC_W-1:0]   HOLD_LD = HC_W'(HOLD_SAMPLES - 1);

    localparam logic [DATA_W-1:0] ON_LVL  = DATA_W'(THRESHOLD);
    localparam logic [DATA_W-1:0] OFF_LVL = DATA_W'(THRESHOLD - HYST);
    localparam logic [DATA_W-1:0] POS_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] NEG_MAX = {1'b1, {(DATA_W-1){1'b0}}};

    localparam logic signed [PW-1:0] RND_C  = PW'(1) << (GAIN_FRAC - 1);
    localparam logic signed [PW-1:0] SAT_HI = PW'((1 << (DATA_W-1)) - 1);
    localparam logic signed [PW-1:0] SAT_LO = PW'(-(1 << (DATA_W-1)));

    logic [2:0]               state_q, state_d;
    logic [GAIN_W-1:0]        gain_q, gain_d;
    logic [HC_W-1:0]          hold_q, hold_d;
    logic [GAIN_W:0]          gain_x, gain_up, gain_dn;
    logic [DATA_W-1:0]        neg_in, abs_in;
    logic                     note_on, note_off, gate_d;

    logic                     s1_valid, s1_bypass, s1_gate;
    logic signed [DATA_W-1:0] s1_sample;
    logic [GAIN_W-1:0]        s1_gain;
    logic signed [PW-1:0]     prod, rounded;
    logic signed [DATA_W-1:0] shaped;

    logic                     out_valid_q;
    logic signed [DATA_W-1:0] out_sample_q;

    // Saturating magnitude of the incoming sample and the two hysteresis decisions
    always_comb begin
        neg_in = -bus.in_sample;
        if (!bus.in_sample[DATA_W-1])
            abs_in = bus.in_sample;
        else if (bus.in_sample == NEG_MAX)
            abs_in = POS_MAX;
        else
            abs_in = neg_in;
        note_on  = abs_in > ON_LVL;
        note_off = abs_in <= OFF_LVL;
    end

    // Envelope next-state and gain for the current sample (committed only when in_valid)
    always_comb begin
        gain_x  = {1'b0, gain_q};
        gain_up = (gain_x + ATK_G >= MAX_G) ? MAX_G : gain_x + ATK_G;
        gain_dn = (gain_x <= MIN_G + REL_G) ? MIN_G : gain_x - REL_G;
        state_d = state_q;
        gain_d  = gain_q;
        hold_d  = hold_q;
        if (!bus.enable) begin
            state_d = S_IDLE;
            gain_d  = MIN_GN;
            hold_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    gain_d = MIN_GN;
                    if (note_on) begin
                        gain_d  = IDLE_UP[GAIN_W-1:0];
                        state_d = (IDLE_UP == MAX_G) ? S_SUSTAIN : S_ATTACK;
                    end
                end
                S_ATTACK: begin
                    if (note_off) begin
                        state_d = S_HOLD;
                        hold_d  = HOLD_LD;
                    end else begin
                        gain_d = gain_up[GAIN_W-1:0];
                        if (gain_up == MAX_G)
                            state_d = S_SUSTAIN;
                    end
                end
                S_SUSTAIN: begin
                    gain_d = MAX_GN;
                    if (note_off) begin
                        state_d = S_HOLD;
                        hold_d  = HOLD_LD;
                    end
                end
                S_HOLD: begin
                    // The sample that exhausts the hold is also the first release step.
                    if (note_on) begin
                        state_d = (gain_x < MAX_G) ? S_ATTACK : S_SUSTAIN;
                    end else if (hold_q == '0) begin
                        gain_d  = gain_dn[GAIN_W-1:0];
                        state_d = (gain_dn == MIN_G) ? S_IDLE : S_RELEASE;
                    end else begin
                        hold_d = hold_q - HC_W'(1);
                    end
                end
                S_RELEASE: begin
                    if (note_on) begin
                        gain_d  = gain_up[GAIN_W-1:0];
                        state_d = (gain_up == MAX_G) ? S_SUSTAIN : S_ATTACK;
                    end else begin
                        gain_d = gain_dn[GAIN_W-1:0];
                        if (gain_dn == MIN_G)
                            state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    gain_d  = MIN_GN;
                    hold_d  = '0;
                end
            endcase
        end
    end

`ifdef ENV_NOISE_GATE_EN
    assign gate_d = bus.enable && (state_d == S_IDLE);
`else
    assign gate_d = 1'b0;
`endif

    // Envelope registers advance only on accepted samples; gaps freeze them
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gain_q  <= MIN_GN;
            hold_q  <= '0;
        end else if (bus.in_valid) begin
            state_q <= state_d;
            gain_q  <= gain_d;
            hold_q  <= hold_d;
        end
    end

    // Stage 1: capture the sample with the gain that was in effect when it arrived
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_sample <= '0;
            s1_gain   <= '0;
            s1_bypass <= 1'b0;
            s1_gate   <= 1'b0;
        end else begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sample <= bus.in_sample;
                s1_gain   <= gain_q;
                s1_bypass <= !bus.enable;
                s1_gate   <= gate_d;
            end
        end
    end

    // Signed multiply, round half up, then clamp to the sample range
    always_comb begin
        prod    = PW'(s1_sample) * PW'($signed({1'b0, s1_gain}));
        rounded = (prod + RND_C) >>> GAIN_FRAC;
        if (rounded > SAT_HI)
            shaped = POS_MAX;
        else if (rounded < SAT_LO)
            shaped = NEG_MAX;
        else
            shaped = rounded[DATA_W-1:0];
    end

    // Stage 2: select bypass, gated zero or shaped sample
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_sample_q <= '0;
        end else begin
            out_valid_q <= s1_valid;
            if (s1_valid)
                out_sample_q <= s1_bypass ? s1_sample : (s1_gate ? '0 : shaped);
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_sample  = out_sample_q;
    assign bus.gain_out    = gain_q;
    assign bus.state_out   = state_q;
    assign bus.note_active = (state_q != S_IDLE);
endmodule

// File: tb/tb_envelope_shaper_adsr.sv
// Bench for envelope_shaper_adsr: directed scenarios plus a randomised run,
// all compared against a sample-level envelope model kept here.
module tb_envelope_shaper_adsr;
    localparam int DATA_W = 16;
    localparam int GAIN_W = 10;
    localparam int GF     = 8;
    localparam int MIN_G  = 64;
    localparam int MAX_G  = 256;
    localparam int ATK    = 8;
    localparam int REL    = 4;
    localparam int TH     = 100;
    localparam int HY     = 20;
    localparam int HOLD   = 4;
`ifdef ENV_NOISE_GATE_EN
    localparam bit GATE = 1'b1;
`else
    localparam bit GATE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    envelope_shaper_adsr_if #(.DATA_W(DATA_W), .GAIN_W(GAIN_W)) bus ();
    envelope_shaper_adsr_if #(.DATA_W(DATA_W), .GAIN_W(GAIN_W)) bus2 ();

    envelope_shaper_adsr #(
        .DATA_W(DATA_W), .GAIN_W(GAIN_W), .GAIN_FRAC(GF), .MIN_GAIN(MIN_G),
        .MAX_GAIN(MAX_G), .ATTACK_STEP(ATK), .RELEASE_STEP(REL),
        .THRESHOLD(TH), .HYST(HY), .HOLD_SAMPLES(HOLD)
    ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    envelope_shaper_adsr #(
        .DATA_W(DATA_W), .GAIN_W(GAIN_W), .GAIN_FRAC(GF), .MIN_GAIN(MIN_G),
        .MAX_GAIN(512), .ATTACK_STEP(ATK), .RELEASE_STEP(REL),
        .THRESHOLD(TH), .HYST(HY), .HOLD_SAMPLES(HOLD)
    ) dut_wide (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int n_vec = 0;
    int n_err = 0;

    // model: phase 0..4 uses the published state codes
    int m_st, m_gain, m_hold;
    bit pend_v, exp_v;
    int pend_s, exp_s;

    function automatic int shape(input int x, input int g);
        int p;
        p = (x * g + (1 << (GF - 1))) >>> GF;
        if (p > 32767) p = 32767;
        if (p < -32768) p = -32768;
        return p;
    endfunction

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_step(input bit en, input int x);
        int a;
        bit on, off;
        a   = (x < 0) ? -x : x;
        if (a > 32767) a = 32767;
        on  = a > TH;
        off = a <= TH - HY;
        if (!en) begin
            m_st = 0; m_gain = MIN_G; m_hold = 0;
        end else if (m_st == 0) begin
            m_gain = MIN_G;
            if (on) begin
                m_gain = min2(MIN_G + ATK, MAX_G);
                m_st   = (m_gain == MAX_G) ? 2 : 1;
            end
        end else if (m_st == 1) begin
            if (off) begin
                m_st = 3; m_hold = HOLD - 1;
            end else begin
                m_gain = min2(m_gain + ATK, MAX_G);
                if (m_gain == MAX_G) m_st = 2;
            end
        end else if (m_st == 2) begin
            m_gain = MAX_G;
            if (off) begin m_st = 3; m_hold = HOLD - 1; end
        end else if (m_st == 3) begin
            if (on) m_st = (m_gain < MAX_G) ? 1 : 2;
            else if (m_hold == 0) begin
                m_gain = max2(m_gain - REL, MIN_G);
                m_st   = (m_gain == MIN_G) ? 0 : 4;
            end else m_hold--;
        end else begin
            if (on) begin
                m_gain = min2(m_gain + ATK, MAX_G);
                m_st   = (m_gain == MAX_G) ? 2 : 1;
            end else begin
                m_gain = max2(m_gain - REL, MIN_G);
                if (m_gain == MIN_G) m_st = 0;
            end
        end
    endtask

    // drive one cycle on the main DUT, advance the model, sample #1 after the edge
    task automatic apply(input bit rn, input bit en, input bit v, input int x);
        int g0;
        rst_n         = rn;
        bus.enable    = en;
        bus.in_valid  = v;
        bus.in_sample = DATA_W'(x);
        @(posedge clk);
        if (!rn) begin
            m_st = 0; m_gain = MIN_G; m_hold = 0;
            pend_v = 0; exp_v = 0; exp_s = 0;
        end else begin
            exp_v = pend_v;
            if (pend_v) exp_s = pend_s;
            pend_v = v;
            if (v) begin
                g0 = m_gain;
                model_step(en, x);
                if (!en) pend_s = x;
                else if (GATE && m_st == 0) pend_s = 0;
                else pend_s = shape(x, g0);
            end
        end
        #1;
    endtask

    function automatic logic [14:0] got_status();
        return {bus.out_valid, bus.state_out, bus.gain_out, bus.note_active};
    endfunction

    function automatic logic [14:0] exp_status();
        return {exp_v, 3'(m_st), 10'(m_gain), m_st != 0};
    endfunction

    task automatic do_reset();
        bus2.in_valid = 1'b0;
        apply(1'b0, 1'b1, 1'b0, 0);
        apply(1'b0, 1'b1, 1'b0, 0);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            apply(1'b0, 1'b1, 1'b1, 1000);
            n_vec++;
            if ({bus.out_valid, bus.out_sample, bus.gain_out, bus.state_out} !==
                {1'b0, 16'sd0, 10'd64, 3'd0}) begin
                n_err++;
                $display("FAIL reset c=%0d got v=%0d s=%0d g=%0d st=%0d want 0/0/64/0",
                         c, bus.out_valid, bus.out_sample, bus.gain_out, bus.state_out);
            end
        end
        apply(1'b1, 1'b1, 1'b1, 1000);
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_latency1 got out_valid=%0d want 0", bus.out_valid);
        end
        apply(1'b1, 1'b1, 1'b0, 0);
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.out_sample !== 16'sd250) begin
            n_err++;
            $display("FAIL reset_first_out got v=%0d s=%0d want 1/250", bus.out_valid, bus.out_sample);
        end
    endtask

    task automatic test_attack(input bit gapped);
        int k;
        do_reset();
        k = 0;
        for (int n = 1; n <= (gapped ? 48 : 24); n++) begin
            bit v;
            v = gapped ? n[0] : 1'b1;
            apply(1'b1, 1'b1, v, 1000);
            if (v) k++;
            n_vec++;
            if (bus.gain_out !== 10'(min2(64 + 8 * k, 256)) ||
                bus.state_out !== ((k == 24) ? 3'd2 : ((k == 0) ? 3'd0 : 3'd1))) begin
                n_err++;
                $display("FAIL attack gap=%0d k=%0d got g=%0d st=%0d want g=%0d",
                         gapped, k, bus.gain_out, bus.state_out, min2(64 + 8 * k, 256));
            end
            n_vec++;
            if (got_status() !== exp_status() || (exp_v && bus.out_sample !== DATA_W'(exp_s))) begin
                n_err++;
                $display("FAIL attack_model gap=%0d n=%0d got %h/%0d want %h/%0d",
                         gapped, n, got_status(), bus.out_sample, exp_status(), exp_s);
            end
        end
    endtask

    task automatic test_release();
        do_reset();
        for (int n = 0; n < 24; n++) apply(1'b1, 1'b1, 1'b1, 1000);
        for (int n = 0; n < 3; n++) begin
            apply(1'b1, 1'b1, 1'b1, 90);
            n_vec++;
            if (bus.state_out !== 3'd2 || bus.gain_out !== 10'd256) begin
                n_err++;
                $display("FAIL hyst_band got st=%0d g=%0d want 2/256", bus.state_out, bus.gain_out);
            end
        end
        for (int i = 1; i <= 52; i++) begin
            int wg, ws;
            apply(1'b1, 1'b1, 1'b1, (i % 2 == 0) ? 50 : -50);
            wg = (i <= 4) ? 256 : 256 - 4 * (i - 4);
            ws = (i <= 4) ? 3 : ((i == 52) ? 0 : 4);
            n_vec++;
            if (bus.gain_out !== 10'(wg) || bus.state_out !== 3'(ws) || bus.note_active !== (ws != 0)) begin
                n_err++;
                $display("FAIL hold_release i=%0d got g=%0d st=%0d na=%0d want g=%0d st=%0d",
                         i, bus.gain_out, bus.state_out, bus.note_active, wg, ws);
            end
            n_vec++;
            if (got_status() !== exp_status() || (exp_v && bus.out_sample !== DATA_W'(exp_s))) begin
                n_err++;
                $display("FAIL release_model i=%0d got %h/%0d want %h/%0d",
                         i, got_status(), bus.out_sample, exp_status(), exp_s);
            end
        end
    endtask

    task automatic test_retrigger();
        do_reset();
        for (int n = 0; n < 24; n++) apply(1'b1, 1'b1, 1'b1, 1000);
        for (int n = 0; n < 18; n++) apply(1'b1, 1'b1, 1'b1, 50);
        n_vec++;
        if (bus.state_out !== 3'd4 || bus.gain_out !== 10'd200) begin
            n_err++; $display("FAIL retrig_pre got st=%0d g=%0d want 4/200", bus.state_out, bus.gain_out);
        end
        apply(1'b1, 1'b1, 1'b1, 1000);
        n_vec++;
        if (bus.state_out !== 3'd1 || bus.gain_out !== 10'd208) begin
            n_err++; $display("FAIL retrigger got st=%0d g=%0d want 1/208", bus.state_out, bus.gain_out);
        end
    endtask

    task automatic test_rounding();
        do_reset();
        apply(1'b1, 1'b1, 1'b1, 3);
        apply(1'b1, 1'b1, 1'b1, -3);
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.out_sample !== (GATE ? 16'sd0 : 16'sd1)) begin
            n_err++; $display("FAIL round_pos got v=%0d s=%0d want 1/%0d", bus.out_valid, bus.out_sample, GATE ? 0 : 1);
        end
        apply(1'b1, 1'b1, 1'b0, 0);
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.out_sample !== (GATE ? 16'sd0 : -16'sd1)) begin
            n_err++; $display("FAIL round_neg got v=%0d s=%0d want 1/%0d", bus.out_valid, bus.out_sample, GATE ? 0 : -1);
        end
    endtask

    task automatic test_bypass();
        do_reset();
        for (int n = 0; n < 3; n++) apply(1'b1, 1'b1, 1'b1, 1000);
        apply(1'b1, 1'b0, 1'b1, -12345);
        n_vec++;
        if (bus.state_out !== 3'd0 || bus.gain_out !== 10'd64 || bus.note_active !== 1'b0) begin
            n_err++; $display("FAIL bypass_state got st=%0d g=%0d want 0/64", bus.state_out, bus.gain_out);
        end
        apply(1'b1, 1'b1, 1'b0, 0);
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.out_sample !== -16'sd12345) begin
            n_err++; $display("FAIL bypass_out got v=%0d s=%0d want 1/-12345", bus.out_valid, bus.out_sample);
        end
`ifdef ENV_NOISE_GATE_EN
        apply(1'b1, 1'b1, 1'b1, 50);
        apply(1'b1, 1'b1, 1'b0, 0);
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.out_sample !== 16'sd0) begin
            n_err++; $display("FAIL noise_gate got v=%0d s=%0d want 1/0", bus.out_valid, bus.out_sample);
        end
`endif
    endtask

    task automatic test_saturation();
        do_reset();
        bus2.enable = 1'b1;
        for (int n = 1; n <= 56; n++) begin
            bus2.in_valid  = 1'b1;
            bus2.in_sample = 16'sd30000;
            apply(1'b1, 1'b1, 1'b0, 0);
            n_vec++;
            if (bus2.gain_out !== 10'(64 + 8 * n) || bus2.state_out !== ((n == 56) ? 3'd2 : 3'd1)) begin
                n_err++;
                $display("FAIL wide_attack n=%0d got g=%0d st=%0d want g=%0d", n, bus2.gain_out, bus2.state_out, 64 + 8 * n);
            end
        end
        bus2.in_sample = 16'sd30000;
        apply(1'b1, 1'b1, 1'b0, 0);
        bus2.in_sample = -16'sd32768;
        apply(1'b1, 1'b1, 1'b0, 0);
        n_vec++;
        if (bus2.out_valid !== 1'b1 || bus2.out_sample !== 16'sd32767) begin
            n_err++; $display("FAIL sat_pos got v=%0d s=%0d want 1/32767", bus2.out_valid, bus2.out_sample);
        end
        bus2.in_valid = 1'b0;
        apply(1'b1, 1'b1, 1'b0, 0);
        n_vec++;
        if (bus2.out_valid !== 1'b1 || bus2.out_sample !== -16'sd32768 || bus2.state_out !== 3'd2) begin
            n_err++; $display("FAIL sat_neg got v=%0d s=%0d st=%0d want 1/-32768/2",
                              bus2.out_valid, bus2.out_sample, bus2.state_out);
        end
    endtask

    task automatic test_random();
        int mode;
        mode = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit rn, en, v;
            int mag, x;
            if (i % 40 == 0) mode = $urandom_range(0, 4);
            rn = ($urandom_range(0, 299) != 0);
            en = ($urandom_range(0, 19) != 0);
            v  = ($urandom_range(0, 3) != 0);
            case (mode)
                0:       mag = $urandom_range(0, 80);
                1:       mag = $urandom_range(81, 100);
                2:       mag = $urandom_range(101, 3000);
                3:       mag = $urandom_range(0, 32768);
                default: mag = $urandom_range(60, 130);
            endcase
            x = ($urandom_range(0, 1) != 0) ? -mag : mag;
            if (x > 32767) x = 32767;
            apply(rn, en, v, x);
            n_vec++;
            if (got_status() !== exp_status() || (exp_v && bus.out_sample !== DATA_W'(exp_s))) begin
                n_err++;
                $display("FAIL random i=%0d got %h/%0d want %h/%0d",
                         i, got_status(), bus.out_sample, exp_status(), exp_s);
            end
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.enable     = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_sample  = '0;
        bus2.enable    = 1'b1;
        bus2.in_valid  = 1'b0;
        bus2.in_sample = '0;
        m_st = 0; m_gain = MIN_G; m_hold = 0;
        pend_v = 0; pend_s = 0; exp_v = 0; exp_s = 0;
        test_reset();
        test_attack(1'b0);
        test_attack(1'b1);
        test_release();
        test_retrigger();
        test_rounding();
        test_bypass();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/envelope_shaper_adsr.md
Name: envelope_shaper_adsr

Overview:
Parametrised successor to the trumpet attack/release envelope shaper. Drives a five-state envelope machine (idle/attack/sustain/hold/release) from the input level, with hysteresis and a hold timer. Applies a rounded, saturated Qx dynamic gain through a 2-stage valid-qualified pipeline. Sits in the trumpet DSP chain after input conditioning and before the output stage.

Parameters:
DATA_W, 16, sample width (signed)
GAIN_W, 10, gain register width (unsigned)
GAIN_FRAC, 8, gain fractional bits (256 = unity at defaults)
MIN_GAIN, 64, gain floor (25%)
MAX_GAIN, 256, gain ceiling; must satisfy MIN_GAIN < MAX_GAIN < 2^GAIN_W
ATTACK_STEP, 8, gain increment per valid sample in ATTACK
RELEASE_STEP, 4, gain decrement per valid sample in RELEASE
THRESHOLD, 100, note-on level: |x| > THRESHOLD
HYST, 20, note-off level: |x| <= THRESHOLD-HYST
HOLD_SAMPLES, 4, valid samples held at current gain before RELEASE (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
enable  in  1  1=shape, 0=bypass; sampled with in_valid
in_valid  in  1  in_sample qualifier
in_sample  in  DATA_W  signed input
out_valid  out  1  in_valid delayed 2 cycles
out_sample  out  DATA_W  signed shaped output
gain_out  out  GAIN_W  current gain register
state_out  out  3  IDLE=0 ATTACK=1 SUSTAIN=2 HOLD=3 RELEASE=4
note_active  out  1  high when state != IDLE

Behaviour:
- Reset (rst_n=0 at posedge): out_valid=0, out_sample=0, gain=MIN_GAIN, state=IDLE, hold counter=0, both pipeline stages flushed. Applies mid-stream; in-flight samples are discarded.
- No backpressure. Pipeline advances every cycle. out_valid is in_valid delayed exactly 2 cycles.
- State and gain update only on cycles with in_valid=1. Gaps freeze the state, the gain and the hold counter.
- abs_in: |in_sample|, saturating (-2^(DATA_W-1) maps to 2^(DATA_W-1)-1).
- note_on = abs_in > THRESHOLD. note_off = abs_in <= THRESHOLD-HYST. Levels between the two leave the state unchanged.
- Stage 1 registers the sample and gain_pre (the gain before this sample's update). The sample is therefore multiplied by the gain in effect when it was accepted.
- Stage 2:
  - p = sample*gain_pre, computed signed at DATA_W+GAIN_W+1 bits.
  - Round: add 2^(GAIN_FRAC-1), then arithmetic shift right by GAIN_FRAC (round half up).
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- State transitions, evaluated per valid sample:
  - IDLE: gain=MIN_GAIN. note_on -> ATTACK (gain += ATTACK_STEP on the same sample).
  - ATTACK:
    - gain = min(gain+ATTACK_STEP, MAX_GAIN).
    - On the sample where gain reaches MAX_GAIN -> SUSTAIN.
    - note_off -> HOLD with counter=HOLD_SAMPLES-1 and gain unchanged. note_off takes priority over the increment.
  - SUSTAIN: gain=MAX_GAIN. note_off -> HOLD with counter loaded.
  - HOLD:
    - Gain frozen.
    - note_on -> ATTACK if gain<MAX_GAIN, else SUSTAIN.
    - Otherwise, counter==0 -> RELEASE; else decrement the counter.
  - RELEASE:
    - gain = max(gain-RELEASE_STEP, MIN_GAIN).
    - note_on -> ATTACK with the increment applied; this takes priority.
    - On the sample where gain reaches MIN_GAIN -> IDLE.
- Bypass (enable=0 on a valid sample):
  - state forced to IDLE, gain forced to MIN_GAIN, counter cleared.
  - That sample passes through unmodified with the same 2-cycle latency; stage 2 selects the raw sample.
- Gain arithmetic uses GAIN_W+1 bits internally, so no wrap-around before the clamp.

Optional Feature:
ENV_NOISE_GATE_EN
- Defined: a sample accepted while the state is IDLE (after that sample's update) outputs 0. Bypass is unaffected.
- Undefined: IDLE samples output sample*MIN_GAIN, rounded, as above.

Test Plan:
- Reset: rst_n=0 for 3 cycles with in_valid=1 and in_sample=1000 -> out_valid=0, out_sample=0, gain_out=64, state_out=0. Release reset; the first output appears 2 cycles after the next valid sample.
- Attack: constant 1000 on every cycle from IDLE:
  - First output is 1000*64/256 = 250, 2 cycles later.
  - gain_out steps 72, 80, … and reaches 256 on valid sample 24, when state_out=2.
  - Repeat with in_valid toggling every other cycle -> same gain sequence per valid sample.
- Hysteresis/hold/release from SUSTAIN:
  - Input 90 -> state stays 2.
  - Input 50 -> state 3 for 4 samples with gain 256, then state 4 with gain 252, 248, ….
  - gain reaches 64 after 48 release samples, then state=0 and note_active=0.
- Retrigger: in RELEASE at gain 200, input 1000 -> state 1, gain 208 on that sample.
- Rounding/saturation:
  - Gain 64: sample 3 -> 1; sample -3 -> -1.
  - Instance with MAX_GAIN=512 at SUSTAIN: 30000 -> 32767; -32768 -> -32768.
- Bypass: enable=0 with input -12345 -> out_sample=-12345 two cycles later, state_out=0, gain_out=64. With ENV_NOISE_GATE_EN defined: enable=1 in IDLE with input 50 -> out_sample=0.
